sccb_init_seq: RTL and testbench

SCCB_INIT_SEQ -- requirements
Module: sccb_init_seq

---
 rtl/sccb_init_seq.sv | 161 ++++++++++++++++
 tb/tb_sccb_init_seq.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sccb_init_seq.sv
// sccb_init_seq: walks an external register-init table and issues one SCCB write per entry.
//
// After reset or start the block waits PWRUP_CYCLES. It then reads the table one entry at a
// time through rom_addr/rom_data, where rom_data is valid one cycle after rom_addr.
//   16'hFFFF : end of table, go to DONE
//   16'hFFF0 : delay marker, wait CMD_DELAY_CYCLES
//   other    : write {DEV_ADDR, reg, value} through the sccb_req/sccb_busy handshake
//
// Ports:
//   sysclk          system clock, rising edge
//   rst             asynchronous active-high reset; the sequence restarts in PWRUP
//   start           single-cycle restart pulse, honoured only in IDLE/DONE/ERROR
//   rom_addr        table index
//   rom_data        table entry {reg, value}
//   sccb_req        one-cycle write request to the SCCB master
//   sccb_send_data  {DEV_ADDR, reg, value}, held from DECODE until the write completes
//   sccb_busy       SCCB master transaction in progress
//   running         high in every state except IDLE, DONE and ERROR
//   done / error    table finished / busy acknowledge timed out
//   cmd_count       completed register writes, saturating at 255
module sccb_init_seq #(
    parameter int unsigned PWRUP_CYCLES     = 3_750_000,
    parameter int unsigned CMD_DELAY_CYCLES = 1_250_000,
    parameter int unsigned BUSY_TIMEOUT     = 1024,
    parameter logic [7:0]  DEV_ADDR         = 8'h42
) (
    input  logic        sysclk,
    input  logic        rst,
    input  logic        start,
    output logic [7:0]  rom_addr,
    input  logic [15:0] rom_data,
    output logic        sccb_req,
    output logic [23:0] sccb_send_data,
    input  logic        sccb_busy,
    output logic        running,
    output logic        done,
    output logic        error,
    output logic [7:0]  cmd_count
);

    typedef enum logic [3:0] {
        StIdle, StPwrup, StFetch, StDecode, StReq,
        StWaitHi, StWaitLo, StDelay, StDone, StError
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [7:0]  index_q, index_d;
    logic [7:0]  cmd_count_q, cmd_count_d;
    logic [23:0] send_data_q, send_data_d;
    logic        req_q, running_q, done_q, error_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        index_d     = index_q;
        cmd_count_d = cmd_count_q;
        send_data_d = send_data_q;
        unique case (state_q)
            StIdle, StDone, StError: begin
                if (start) begin
                    state_d     = StPwrup;
                    cnt_d       = '0;
                    index_d     = '0;
                    cmd_count_d = '0;
                end
            end
            StPwrup: begin
                if (cnt_q + 32'd1 >= PWRUP_CYCLES) begin
                    state_d = StFetch;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            StFetch: state_d = StDecode;
            StDecode: begin
                if (rom_data == 16'hFFFF) begin
                    state_d = StDone;
                end else if (rom_data == 16'hFFF0) begin
                    // Index saturates; DELAY checks for 255 when it ends.
                    if (index_q != 8'hFF) index_d = index_q + 8'd1;
                    cnt_d   = '0;
                    state_d = StDelay;
                end else begin
                    send_data_d = {DEV_ADDR, rom_data};
                    state_d     = StReq;
                end
            end
            StReq: begin
                // The request cycle counts toward the acknowledge timeout.
                cnt_d   = 32'd1;
                state_d = StWaitHi;
            end
            StWaitHi: begin
                if (sccb_busy) begin
                    state_d = StWaitLo;
                end else if (cnt_q + 32'd1 >= BUSY_TIMEOUT) begin
                    state_d = StError;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            StWaitLo: begin
                if (!sccb_busy) begin
                    if (cmd_count_q != 8'hFF) cmd_count_d = cmd_count_q + 8'd1;
                    if (index_q >= 8'd254) begin
                        index_d = 8'hFF;
                        state_d = StDone;
                    end else begin
                        index_d = index_q + 8'd1;
                        state_d = StFetch;
                    end
                end
            end
            StDelay: begin
                if (cnt_q + 32'd1 >= CMD_DELAY_CYCLES) begin
                    cnt_d   = '0;
                    state_d = (index_q == 8'hFF) ? StDone : StFetch;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            state_q     <= StPwrup;
            cnt_q       <= '0;
            index_q     <= '0;
            cmd_count_q <= '0;
            send_data_q <= '0;
            req_q       <= 1'b0;
            running_q   <= 1'b1;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            index_q     <= index_d;
            cmd_count_q <= cmd_count_d;
            send_data_q <= send_data_d;
            req_q       <= (state_d == StReq);
            running_q   <= !(state_d inside {StIdle, StDone, StError});
            done_q      <= (state_d == StDone);
            error_q     <= (state_d == StError);
        end
    end

    assign rom_addr       = index_q;
    assign sccb_req       = req_q;
    assign sccb_send_data = send_data_q;
    assign running        = running_q;
    assign done           = done_q;
    assign error          = error_q;
    assign cmd_count      = cmd_count_q;

endmodule

// File: tb/tb_sccb_init_seq.sv
// Randomized scoreboard bench for sccb_init_seq with small timing parameters.
module tb_sccb_init_seq;

    localparam int unsigned PWRUP = 10;
    localparam int unsigned CDLY  = 5;
    localparam int unsigned BTO   = 8;

    logic        sysclk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  rom_addr;
    logic [15:0] rom_data = 16'h0;
    logic        sccb_req;
    logic [23:0] sccb_send_data;
    logic        sccb_busy = 1'b0;
    logic        running, done, error;
    logic [7:0]  cmd_count;

    sccb_init_seq #(
        .PWRUP_CYCLES    (PWRUP),
        .CMD_DELAY_CYCLES(CDLY),
        .BUSY_TIMEOUT    (BTO),
        .DEV_ADDR        (8'h42)
    ) dut (
        .sysclk        (sysclk),
        .rst           (rst),
        .start         (start),
        .rom_addr      (rom_addr),
        .rom_data      (rom_data),
        .sccb_req      (sccb_req),
        .sccb_send_data(sccb_send_data),
        .sccb_busy     (sccb_busy),
        .running       (running),
        .done          (done),
        .error         (error),
        .cmd_count     (cmd_count)
    );

    always #5 sysclk = ~sysclk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Table memory with one cycle read latency.
    logic [15:0] rom [256];
    always @(posedge sysclk) rom_data <= rom[rom_addr];

    // Busy responder: mode 0 never answers, mode 1 raises busy for cycles
    // [lat, lat+len) counted from the request cycle.
    int busy_mode = 1;
    int busy_lat  = 2;
    int busy_len  = 20;
    int k = 0;
    always @(posedge sysclk) begin
        int kn;
        if (rst) kn = 0;
        else if (sccb_req) kn = 1;
        else if (k != 0 && k < 10000) kn = k + 1;
        else kn = 0;
        k <= kn;
        if (busy_mode == 1) sccb_busy <= (kn != 0 && kn >= busy_lat && kn < busy_lat + busy_len);
        else sccb_busy <= 1'b0;
    end

    int cyc = 0;
    always @(posedge sysclk) cyc <= cyc + 1;

    // Monitor: pops the scoreboard on every request and tracks address progress.
    logic [23:0] exp_q [$];
    logic        prev_req = 1'b0;
    int          req_count = 0;
    int          last_req_cyc = 0;
    int          gap_last = 0;
    logic        seen_nz = 1'b0;
    int          wrap_events = 0;
    always @(negedge sysclk) begin
        if (!rst && sccb_req) begin
            if (prev_req) chk("req_one_cycle", 32'(prev_req), 32'd0);
            chk("req_data", 32'(sccb_send_data),
                (exp_q.size() != 0) ? 32'(exp_q.pop_front()) : 32'hDEAD_BEEF);
            gap_last     <= cyc - last_req_cyc;
            last_req_cyc <= cyc;
            req_count    <= req_count + 1;
        end
        if (!rst && prev_req && !sccb_req) chk("req_data_hold", 32'(sccb_send_data),
                                               32'(dut.send_data_q));
        prev_req <= sccb_req & ~rst;
        if (rst || !running) seen_nz <= 1'b0;
        else if (rom_addr != 8'd0) seen_nz <= 1'b1;
        else if (seen_nz) wrap_events <= wrap_events + 1;
    end

    // Reference model: writes are every non-marker entry before the end marker, index < 255.
    task automatic model_push(output int n);
        n = 0;
        for (int i = 0; i < 255; i++) begin
            if (rom[i] == 16'hFFFF) break;
            if (rom[i] != 16'hFFF0) begin
                exp_q.push_back({8'h42, rom[i]});
                n++;
            end
        end
    endtask

    task automatic fill(input logic [15:0] v);
        for (int i = 0; i < 256; i++) rom[i] = v;
    endtask

    task automatic pulse_start();
        @(negedge sysclk) start = 1'b1;
        @(negedge sysclk) start = 1'b0;
    endtask

    task automatic wait_end(input string name, input int bound);
        int n = 0;
        while (!(done || error) && n < bound) begin
            @(negedge sysclk);
            n++;
        end
        chk({name, "_finished"}, 32'(done | error), 32'd1);
    endtask

    task automatic end_checks(input string name, input logic exp_done, input int exp_cnt);
        chk({name, "_done"}, 32'(done), 32'(exp_done));
        chk({name, "_error"}, 32'(error), 32'(!exp_done));
        chk({name, "_running"}, 32'(running), 32'd0);
        chk({name, "_cmd_count"}, 32'(cmd_count), 32'(exp_cnt));
        chk({name, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int n, base, t_rel;
        fill(16'hFFFF);

        // Reset values.
        repeat (3) @(negedge sysclk);
        chk("rst_rom_addr", 32'(rom_addr), 0);
        chk("rst_req", 32'(sccb_req), 0);
        chk("rst_send_data", 32'(sccb_send_data), 0);
        chk("rst_running", 32'(running), 1);
        chk("rst_done", 32'(done), 0);
        chk("rst_error", 32'(error), 0);
        chk("rst_cmd_count", 32'(cmd_count), 0);

        // Basic table with a delay marker; runs automatically after reset release.
        rom[0] = 16'h1280; rom[1] = 16'hFFF0; rom[2] = 16'h1104; rom[3] = 16'hFFFF;
        busy_mode = 1; busy_lat = 2; busy_len = 20;
        model_push(n);
        rst = 1'b0;
        repeat (3) @(negedge sysclk);
        pulse_start();  // ignored while powering up
        wait_end("basic", 3000);
        end_checks("basic", 1'b1, n);
        chk("basic_gap_ge5", 32'(gap_last >= 5), 1);

        // Timeout: busy never answers.
        fill(16'hFFFF);
        rom[0] = 16'h3A04;
        busy_mode = 0;
        exp_q.push_back(24'h423A04);
        pulse_start();
        chk("restart_done_clear", 32'(done), 0);
        chk("restart_cmd_count", 32'(cmd_count), 0);
        wait_end("timeout", 3000);
        end_checks("timeout", 1'b0, 0);
        chk("timeout_latency", 32'(cyc - last_req_cyc), 32'(BTO));

        // Busy already high on entry to WAIT_HI and held past the timeout.
        fill(16'hFFFF);
        rom[0] = 16'h0A55; rom[1] = 16'h0B66;
        busy_mode = 1; busy_lat = 1; busy_len = 15;
        model_push(n);
        pulse_start();
        wait_end("busy_early", 3000);
        end_checks("busy_early", 1'b1, n);

        // No end marker: 255 writes, then stop without wrapping.
        fill(16'h0101);
        busy_lat = 1; busy_len = 1;
        model_push(n);
        pulse_start();
        wait_end("full", 6000);
        end_checks("full", 1'b1, n);
        chk("full_no_wrap", 32'(wrap_events), 0);
        chk("full_rom_addr", 32'(rom_addr), 32'hFF);

        // Random tables, random busy timing, start pulses while running are ignored.
        for (int it = 0; it < 8; it++) begin
            int len;
            fill(16'hFFFF);
            len = $urandom_range(0, 16);
            for (int i = 0; i < len; i++) begin
                logic [15:0] e;
                e = 16'($urandom);
                if ($urandom_range(0, 6) == 0) e = 16'hFFF0;
                else if (e >= 16'hFFF0) e = 16'h1234;
                rom[i] = e;
            end
            busy_lat = $urandom_range(1, 7);
            busy_len = $urandom_range(1, 12);
            model_push(n);
            pulse_start();
            repeat ($urandom_range(1, 60)) @(negedge sysclk);
            if (running) pulse_start();
            wait_end("rand", 5000);
            end_checks("rand", 1'b1, n);
        end

        // Reset in WAIT_LO of the second write.
        fill(16'hFFFF);
        for (int i = 0; i < 5; i++) rom[i] = 16'(16'h2000 + i);
        busy_lat = 2; busy_len = 20;
        model_push(n);
        base = req_count;
        pulse_start();
        for (int w = 0; w < 3000 && req_count < base + 2; w++) @(negedge sysclk);
        chk("mid_second_req_seen", 32'(req_count - base), 2);
        repeat (4) @(negedge sysclk);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_req", 32'(sccb_req), 0);
        chk("mid_rst_cmd_count", 32'(cmd_count), 0);
        chk("mid_rst_running", 32'(running), 1);
        chk("mid_rst_rom_addr", 32'(rom_addr), 0);
        repeat (3) @(negedge sysclk);
        exp_q.delete();
        model_push(n);
        base = req_count;
        t_rel = cyc;
        rst = 1'b0;
        for (int w = 0; w < 3000 && req_count == base; w++) @(negedge sysclk);
        chk("mid_restart_delay_ge10", 32'((last_req_cyc - t_rel) >= 10), 1);
        wait_end("mid", 3000);
        end_checks("mid", 1'b1, n);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #900_000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

endmodule
